// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder.
// Holds funct3 access codes, the FSM state type, byte-enable lane constants
// and small decode helpers used by the top level and the lane aligner.
package data_mem_responder_pkg;

    // Load funct3 codes (instr[14:12]).
    localparam logic [2:0] Funct3Lb  = 3'd0;
    localparam logic [2:0] Funct3Lh  = 3'd1;
    localparam logic [2:0] Funct3Lw  = 3'd2;
    localparam logic [2:0] Funct3Lbu = 3'd4;
    localparam logic [2:0] Funct3Lhu = 3'd5;

    // Store funct3 codes.
    localparam logic [2:0] Funct3Sb  = 3'd0;
    localparam logic [2:0] Funct3Sh  = 3'd1;
    localparam logic [2:0] Funct3Sw  = 3'd2;

    // Byte-enable lane patterns.
    localparam logic [3:0] BeLane0    = 4'b0001;
    localparam logic [3:0] BeLowHalf  = 4'b0011;
    localparam logic [3:0] BeHighHalf = 4'b1100;
    localparam logic [3:0] BeWord     = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return (f3 == Funct3Sb) || (f3 == Funct3Sh) || (f3 == Funct3Sw);
        end
        return (f3 == Funct3Lb) || (f3 == Funct3Lh) || (f3 == Funct3Lw) ||
               (f3 == Funct3Lbu) || (f3 == Funct3Lhu);
    endfunction

    // Size lives in f3[1:0]: 0 byte, 1 half, 2 word.
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd1:    return (lo[0] == 1'b0);
            2'd2:    return (lo == 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_aligner.sv
// load_store_aligner: purely combinational lane logic.
// Store side: replicates store data across lanes and builds byte enables.
// Load side: extracts the addressed lane from the bus word and extends it.
// Ports:
//   st_we_i/st_funct3_i/st_addr_lo_i/st_wdata_i : store-side request fields
//   st_wdata_o/st_be_o                          : lane-steered data and enables
//   ld_funct3_i/ld_addr_lo_i/ld_raw_i           : latched load fields, bus word
//   ld_data_o                                   : extended load result
module load_store_aligner
    import data_mem_responder_pkg::*;
(
    input  logic        st_we_i,
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_addr_lo_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_wdata_o = st_wdata_i;
        st_be_o    = BeWord;
        if (st_we_i) begin
            case (st_funct3_i[1:0])
                2'd0: begin
                    st_wdata_o = {4{st_wdata_i[7:0]}};
                    st_be_o    = BeLane0 << st_addr_lo_i;
                end
                2'd1: begin
                    st_wdata_o = {2{st_wdata_i[15:0]}};
                    st_be_o    = st_addr_lo_i[1] ? BeHighHalf : BeLowHalf;
                end
                default: begin
                    st_wdata_o = st_wdata_i;
                    st_be_o    = BeWord;
                end
            endcase
        end
    end

    always_comb begin
        ld_shifted = ld_raw_i >> {ld_addr_lo_i, 3'b000};
        ld_byte    = ld_shifted[7:0];
        ld_half    = ld_addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        case (ld_funct3_i)
            Funct3Lb:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            Funct3Lh:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            Funct3Lbu: ld_data_o = {24'd0, ld_byte};
            Funct3Lhu: ld_data_o = {16'd0, ld_half};
            default:   ld_data_o = ld_raw_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: turns core load/store requests into single word-bus
// transactions, stalling the core until the bus acknowledges or times out.
// Ports:
//   clk, reset_n (sync, active-low)
//   should_read_mem/should_write_mem/funct3/addr/wdata : core request
//   stall, rdata, rdata_valid, fault                   : core response
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be           : word bus request
//   bus_ack/bus_rdata                                  : word bus response
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        should_read_mem,
    input  logic        should_write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    logic [31:0] cnt_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;

    logic        in_idle, in_busy, in_done;
    logic        req_any, req_ok, req_bad, timeout;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] ld_data;

    assign in_idle = (state_q == StIdle);
    assign in_busy = (state_q == StBusy);
    assign in_done = (state_q == StDone);

    assign req_any = should_read_mem | should_write_mem;
    assign req_ok  = in_idle && req_any && !(should_read_mem && should_write_mem) &&
                     funct3_legal(should_write_mem, funct3) && addr_aligned(funct3, addr[1:0]);
    assign req_bad = in_idle && req_any && !req_ok;

    // Ack on the final allowed cycle wins over the timeout.
    assign timeout = in_busy && !bus_ack && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    load_store_aligner u_aligner (
        .st_we_i      (should_write_mem),
        .st_funct3_i  (funct3),
        .st_addr_lo_i (addr[1:0]),
        .st_wdata_i   (wdata),
        .st_wdata_o   (st_wdata),
        .st_be_o      (st_be),
        .ld_funct3_i  (f3_q),
        .ld_addr_lo_i (lo_q),
        .ld_raw_i     (bus_rdata),
        .ld_data_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_ok) state_d = StBusy;
            StBusy:  if (bus_ack || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (in_idle && req_ok) begin
                cnt_q   <= '0;
                we_q    <= should_write_mem;
                addr_q  <= {addr[31:2], 2'b00};
                wdata_q <= st_wdata;
                be_q    <= st_be;
                f3_q    <= funct3;
                lo_q    <= addr[1:0];
            end else if (in_busy) begin
                if (bus_ack) begin
                    if (!we_q) rdata_q <= ld_data;
                end else if (timeout) begin
                    rdata_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 32'd1;
                end
            end
        end
    end

    assign stall       = req_ok || in_busy;
    assign fault       = req_bad || timeout;
    assign rdata       = rdata_q;
    assign rdata_valid = in_done && !we_q;
    assign bus_req     = in_busy;
    assign bus_we      = in_busy && we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign bus_be      = in_busy ? be_q : 4'b0000;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        should_read_mem, should_write_mem;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, fault;
    logic [31:0] rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    data_mem_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .should_read_mem  (should_read_mem),
        .should_write_mem (should_write_mem),
        .funct3           (funct3),
        .addr             (addr),
        .wdata            (wdata),
        .stall            (stall),
        .rdata            (rdata),
        .rdata_valid      (rdata_valid),
        .fault            (fault),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_be           (bus_be),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference rules written from the access semantics, not the RTL structure.
    function automatic logic m_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int sz;
        if (rd && wr) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        if (rd && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
        sz = 1 << (f3 % 4);
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] m_be(input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a);
        if (!wr) return 32'hF;
        if (f3 == 3'd0) return 32'd1 << (a % 4);
        if (f3 == 3'd1) return (a % 4 >= 2) ? 32'hC : 32'h3;
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd % 256) * 32'h01010101;
        if (f3 == 3'd1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] raw);
        logic [31:0] b, h;
        b = (raw >> (8 * (a % 4))) % 256;
        h = (raw >> (8 * (a % 4))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    task automatic clear_req();
        should_read_mem  = 1'b0;
        should_write_mem = 1'b0;
    endtask

    // One transaction from IDLE. ack_lat in 1..TO acks in that BUSY cycle; else timeout.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int ack_lat, input logic [31:0] brd);
        logic ok;
        logic acked;
        @(negedge clk);
        should_read_mem  = rd;
        should_write_mem = wr;
        funct3           = f3;
        addr             = a;
        wdata            = wd;
        bus_ack          = 1'($urandom_range(0, 1));
        bus_rdata        = $urandom;
        #1;
        ok = m_legal(rd, wr, f3, a);
        check_eq("idle_rdata_hold", rdata, exp_rdata);
        check_eq("idle_rdata_valid", 32'(rdata_valid), 32'd0);
        check_eq("req_stall", 32'(stall), 32'(ok));
        check_eq("req_fault", 32'(fault), 32'(!ok));
        check_eq("req_bus_req", 32'(bus_req), 32'd0);
        if (!ok) begin
            @(negedge clk);
            clear_req();
            #1;
            check_eq("bad_fault_end", 32'(fault), 32'd0);
            check_eq("bad_stay_idle", 32'(bus_req), 32'd0);
            return;
        end
        acked = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            clear_req();
            funct3    = 3'($urandom);
            addr      = $urandom;
            wdata     = $urandom;
            bus_ack   = (k == ack_lat);
            bus_rdata = (k == ack_lat) ? brd : $urandom;
            #1;
            check_eq("busy_req", 32'(bus_req), 32'd1);
            check_eq("busy_stall", 32'(stall), 32'd1);
            check_eq("busy_we", 32'(bus_we), 32'(wr));
            check_eq("busy_addr", bus_addr, a & 32'hFFFFFFFC);
            check_eq("busy_be", 32'(bus_be), m_be(wr, f3, a));
            if (wr) check_eq("busy_wdata", bus_wdata, m_wdata(f3, wd));
            check_eq("busy_fault", 32'(fault), 32'(k == TO && k != ack_lat));
            if (k == ack_lat) begin
                acked = 1'b1;
                if (rd) exp_rdata = m_load(f3, a, brd);
                break;
            end
        end
        if (!acked) exp_rdata = 32'd0;
        @(negedge clk);
        // Requests in DONE must be ignored.
        should_read_mem  = 1'($urandom_range(0, 1));
        should_write_mem = 1'($urandom_range(0, 1));
        bus_ack          = 1'($urandom_range(0, 1));
        #1;
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("done_fault", 32'(fault), 32'd0);
        check_eq("done_bus_req", 32'(bus_req), 32'd0);
        check_eq("done_valid", 32'(rdata_valid), 32'(rd));
        check_eq("done_rdata", rdata, exp_rdata);
        clear_req();
    endtask

    initial begin
        reset_n = 1'b0;
        clear_req();
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_valid", 32'(rdata_valid), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_bus_req", 32'(bus_req), 32'd0);
        check_eq("rst_bus_we", 32'(bus_we), 32'd0);
        check_eq("rst_bus_be", 32'(bus_be), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases.
        run_txn(1, 0, 3'd2, 32'h100, 32'd0, 2, 32'hDEADBEEF);
        check_eq("lw_example", rdata, 32'hDEADBEEF);
        run_txn(1, 0, 3'd0, 32'h203, 32'd0, 1, 32'h80FFFFFF);
        check_eq("lb_example", rdata, 32'hFFFFFF80);
        run_txn(1, 0, 3'd4, 32'h203, 32'd0, 1, 32'h80FFFFFF);
        check_eq("lbu_example", rdata, 32'h00000080);
        run_txn(0, 1, 3'd1, 32'h12, 32'h0000ABCD, 1, 32'd0);
        run_txn(1, 0, 3'd2, 32'h102, 32'd0, 1, 32'd0);
        run_txn(1, 0, 3'd1, 32'h41, 32'd0, 1, 32'd0);
        run_txn(1, 0, 3'd3, 32'h40, 32'd0, 1, 32'd0);
        run_txn(0, 1, 3'd4, 32'h40, 32'd0, 1, 32'd0);
        run_txn(1, 1, 3'd2, 32'h40, 32'd0, 1, 32'd0);
        run_txn(1, 0, 3'd5, 32'h22, 32'd0, 0, 32'h12345678);
        run_txn(1, 0, 3'd1, 32'h22, 32'd0, TO, 32'h8765_4321);
        check_eq("lh_upper", rdata, 32'hFFFF8765);

        // Reset in the second BUSY cycle, then a stray ack.
        @(negedge clk);
        should_read_mem = 1'b1;
        funct3          = 3'd2;
        addr            = 32'h300;
        bus_ack         = 1'b0;
        @(negedge clk);
        clear_req();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("rstbusy_req_before", 32'(bus_req), 32'd1);
        @(negedge clk);
        reset_n   = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFEF00D;
        #1;
        check_eq("rstbusy_bus_req", 32'(bus_req), 32'd0);
        check_eq("rstbusy_valid", 32'(rdata_valid), 32'd0);
        check_eq("rstbusy_fault", 32'(fault), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check_eq("rstbusy_valid2", 32'(rdata_valid), 32'd0);
        check_eq("rstbusy_fault2", 32'(fault), 32'd0);
        check_eq("rstbusy_rdata", rdata, 32'd0);
        exp_rdata = 32'd0;

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            run_txn(rd, wr, 3'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, TO + 1)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
